button_debouncer: RTL and testbench

- Conditions the raw push-button pin (pulsador) into a clean, clock-synchronous level plus single-cycle press/release event pulses.
- Sits directly upstream of the LED counter/display logic in the top level, which consumes only btn_press.
- Target clock is 27 MHz. Contact bounce of 100–300 µs must be rejected; a press held stable for 1 ms is accepted.

---
 rtl/button_debouncer_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/button_debouncer.sv | 144 ++++++++++++++
 tb/tb_button_debouncer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
//   state_e        : debouncer FSM state encoding (2 bits)
//   us_to_cycles() : converts a time in microseconds to clock cycles
//   DEF_*          : default clock frequency and timing constants
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        StIdleLow  = 2'd0,
        StWaitHigh = 2'd1,
        StIdleHigh = 2'd2,
        StWaitLow  = 2'd3
    } state_e;

    localparam int unsigned DEF_CLK_FREQ_HZ = 27_000_000;
    localparam int unsigned DEF_STABLE_US   = 1000;
    localparam int unsigned DEF_LONG_US     = 500_000;

    // Integer MHz first so large microsecond values stay within 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned us);
        return (freq_hz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i cycles of latency)
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw pin and only accepts a new level once it has
// been stable for STABLE_US microseconds. Produces a clean level plus one-cycle press/release
// pulses that coincide with the level change.
// Optional feature (macro BUTTON_DEBOUNCER_LONG_PRESS_EN): one-cycle long_press_o pulse when a
// press is held for LONG_US microseconds; without the macro long_press_o is tied low.
//   clk_i         : system clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   pulsador_i    : raw asynchronous button input, 1 = pressed
//   btn_level_o   : debounced button level
//   btn_press_o   : one-cycle pulse on accepted 0->1
//   btn_release_o : one-cycle pulse on accepted 1->0
//   long_press_o  : one-cycle pulse after a long hold (optional feature)
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned STABLE_US   = DEF_STABLE_US,
    parameter int unsigned LONG_US     = DEF_LONG_US
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulsador_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic long_press_o
);

    localparam int unsigned STABLE_CYCLES = us_to_cycles(CLK_FREQ_HZ, STABLE_US);
    localparam int unsigned LONG_CYCLES   = us_to_cycles(CLK_FREQ_HZ, LONG_US);
    localparam int unsigned CntW          = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $fatal(1, "button_debouncer: STABLE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $fatal(1, "button_debouncer: LONG_CYCLES must be at least 2");
    end

    logic sync_in;

    sync_2ff #(
        .Width (1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pulsador_i),
        .q_o    (sync_in)
    );

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdleLow;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                StIdleLow: begin
                    if (sync_in) begin
                        state_q <= StWaitHigh;
                        cnt_q   <= CntW'(1);
                    end
                end
                StWaitHigh: begin
                    if (!sync_in) begin
                        state_q <= StIdleLow;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q <= StIdleHigh;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIdleHigh: begin
                    if (!sync_in) begin
                        state_q <= StWaitLow;
                        cnt_q   <= CntW'(1);
                    end
                end
                StWaitLow: begin
                    if (sync_in) begin
                        state_q <= StIdleHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q   <= StIdleLow;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned LongW = $clog2(LONG_CYCLES) + 1;
    localparam logic [LongW-1:0] LongSat = LongW'(LONG_CYCLES);

    logic [LongW-1:0] long_cnt_q;
    logic             long_q;

    // Counts only in StIdleHigh, holds through StWaitLow bounces and is cleared whenever the
    // button is (or is becoming) low. Saturating at LONG_CYCLES makes the pulse one-shot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state_q == StIdleLow || state_q == StWaitHigh) begin
                long_cnt_q <= '0;
            end else if (state_q == StIdleHigh && long_cnt_q != LongSat) begin
                long_cnt_q <= long_cnt_q + 1'b1;
                long_q     <= (long_cnt_q == LongSat - 1'b1);
            end
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with 10-cycle stable time and
// 50-cycle long press. Inputs change and outputs are sampled on the falling clock edge.
module tb_button_debouncer;

    logic clk;
    logic rst_n;
    logic pulsador;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic long_press;

    int checks = 0;
    int errors = 0;

    // Per-cycle monitor state.
    int cyc = 0;
    int n_press = 0;
    int n_release = 0;
    int n_long = 0;
    int press_cyc = -1;
    int release_cyc = -1;
    int long_cyc = -1;
    int level_rise_cyc = -1;
    int level_fall_cyc = -1;
    int rst_viol = 0;
    int consec = 0;
    logic prev_level = 1'b0;
    logic prev_press = 1'b0;
    logic prev_release = 1'b0;
    logic prev_long = 1'b0;

    int t0;

    button_debouncer #(
        .CLK_FREQ_HZ (1_000_000),
        .STABLE_US   (10),
        .LONG_US     (50)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pulsador_i    (pulsador),
        .btn_level_o   (btn_level),
        .btn_press_o   (btn_press),
        .btn_release_o (btn_release),
        .long_press_o  (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_n && (btn_level || btn_press || btn_release || long_press)) rst_viol++;
        if (btn_press) begin n_press++; press_cyc = cyc; end
        if (btn_release) begin n_release++; release_cyc = cyc; end
        if (long_press) begin n_long++; long_cyc = cyc; end
        if (btn_level && !prev_level) level_rise_cyc = cyc;
        if (!btn_level && prev_level) level_fall_cyc = cyc;
        if ((btn_press && prev_press) || (btn_release && prev_release) ||
            (long_press && prev_long)) consec++;
        prev_level   = btn_level;
        prev_press   = btn_press;
        prev_release = btn_release;
        prev_long    = long_press;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_press = 0;
        n_release = 0;
        n_long = 0;
        press_cyc = -1;
        release_cyc = -1;
        long_cyc = -1;
    endtask

    int long_total = 0;

    initial begin
        rst_n    = 1'b0;
        pulsador = 1'b0;

        // 1. Reset with a toggling pin, then release with the pin low.
        for (int i = 0; i < 5; i++) begin
            pulsador = ~pulsador;
            tick();
        end
        check("reset_outputs_low", rst_viol, 0);
        pulsador = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(20);
        check("post_reset_level", int'(btn_level), 0);
        check("post_reset_press", n_press, 0);
        check("post_reset_release", n_release, 0);

        // 2. Clean press held 30 cycles.
        clear_counts();
        pulsador = 1'b1;
        t0 = cyc;
        ticks(30);
        check("clean_press_count", n_press, 1);
        check("clean_press_latency", press_cyc - t0, 12);
        check("clean_level_with_press", level_rise_cyc, press_cyc);
        check("clean_no_release", n_release, 0);
        check("clean_level_high", int'(btn_level), 1);
        long_total += n_long;

        // Clean release back to idle low.
        clear_counts();
        pulsador = 1'b0;
        t0 = cyc;
        ticks(30);
        check("clean_release_count", n_release, 1);
        check("clean_release_latency", release_cyc - t0, 12);
        check("clean_level_low", int'(btn_level), 0);
        long_total += n_long;

        // 3. Bouncy press: high 4, low 3, high 6, low 2, then high.
        clear_counts();
        pulsador = 1'b1; ticks(4);
        pulsador = 1'b0; ticks(3);
        pulsador = 1'b1; ticks(6);
        pulsador = 1'b0; ticks(2);
        check("bounce_no_early_press", n_press, 0);
        pulsador = 1'b1;
        t0 = cyc;
        ticks(30);
        check("bounce_press_count", n_press, 1);
        check("bounce_press_latency", press_cyc - t0, 12);
        check("bounce_no_release", n_release, 0);
        long_total += n_long;

        // 4. Bouncy release: low 5, high 2, then low.
        clear_counts();
        pulsador = 1'b0; ticks(5);
        pulsador = 1'b1; ticks(2);
        check("rel_bounce_no_early", n_release, 0);
        pulsador = 1'b0;
        t0 = cyc;
        ticks(30);
        check("rel_bounce_count", n_release, 1);
        check("rel_bounce_latency", release_cyc - t0, 12);
        check("rel_level_fall_with_pulse", level_fall_cyc, release_cyc);
        check("rel_no_extra_press", n_press, 0);
        check("rel_level_low", int'(btn_level), 0);
        long_total += n_long;

        // 5. Reset in the middle of a candidate rise, pin held high across release.
        clear_counts();
        rst_viol = 0;
        pulsador = 1'b1;
        ticks(7);
        check("midcount_no_press", n_press, 0);
        rst_n = 1'b0;
        ticks(3);
        check("midcount_reset_outputs", rst_viol, 0);
        check("midcount_no_press_in_reset", n_press, 0);
        rst_n = 1'b1;
        t0 = cyc;
        ticks(30);
        check("midcount_press_count", n_press, 1);
        check("midcount_press_latency", press_cyc - t0, 12);
        long_total += n_long;

        // 6. Long hold of 120 cycles.
        pulsador = 1'b0;
        ticks(30);
        clear_counts();
        pulsador = 1'b1;
        t0 = cyc;
        ticks(120);
        check("long_hold_press_count", n_press, 1);
        check("long_hold_press_latency", press_cyc - t0, 12);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        check("long_press_count", n_long, 1);
        check("long_press_delay", long_cyc - press_cyc, 50);
        check("long_press_none_before", long_total, 0);
`else
        long_total += n_long;
        check("long_press_tied_low", long_total, 0);
`endif
        pulsador = 1'b0;
        ticks(30);
        check("long_hold_release_count", n_release, 1);

        check("no_consecutive_pulses", consec, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
